// File: rtl/moving_avg_pkg.sv
// Shared arithmetic definitions for the averaging pipeline (also used by the
// upstream two-input mean stage).
//   SIGN_UNSIGNED / SIGN_SIGNED : encodings of the 'sign' control input
//   sum_width()                 : accumulator width that can hold N samples
package moving_avg_pkg;

    localparam logic SIGN_UNSIGNED = 1'b0;
    localparam logic SIGN_SIGNED   = 1'b1;

    // Width of a sum of 2**log2_n samples of 'width' bits, with no overflow.
    function automatic int sum_width(input int width, input int log2_n);
        return width + log2_n;
    endfunction

endpackage

// File: rtl/moving_avg_if.sv
// Sample stream interface between the mean stage and the windowed averager.
//   DIN/ivalid   : incoming sample and its qualifier
//   DOUT/ovalid  : windowed mean and its one-cycle valid pulse
//   primed       : window is filled with N real samples
// master = producer/consumer side (testbench or upstream), slave = averager.
interface moving_avg_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] DIN;
    logic             ivalid;
    logic [WIDTH-1:0] DOUT;
    logic             ovalid;
    logic             primed;

    modport master (output DIN, ivalid, input DOUT, ovalid, primed);
    modport slave  (input DIN, ivalid, output DOUT, ovalid, primed);
endinterface

// File: rtl/moving_avg_ring.sv
// Circular buffer of N = 2**LOG2_N samples.
//   clock, reset_n : clock and async active-low reset
//   i_clear        : synchronous clear of every slot and the write pointer
//   i_wr_en        : write i_din into the current slot and advance the pointer
//   i_din          : sample to store
//   o_old          : content of the slot about to be overwritten (the sample
//                    leaving the window), valid in the same cycle as the write
module moving_avg_ring #(
    parameter int WIDTH  = 16,
    parameter int LOG2_N = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_clear,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_old
);
    localparam int N = 1 << LOG2_N;

    logic [WIDTH-1:0]  r_slots [N];
    logic [LOG2_N-1:0] r_wr_ptr;

    // The pointer is exactly LOG2_N bits wide, so N-1 -> 0 wraps for free.
    assign o_old = r_slots[r_wr_ptr];

    // Slot storage and write pointer; clear empties the window in one cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                r_slots[i] <= '0;
            end
            r_wr_ptr <= '0;
        end else if (i_clear) begin
            for (int i = 0; i < N; i++) begin
                r_slots[i] <= '0;
            end
            r_wr_ptr <= '0;
        end else if (i_wr_en) begin
            r_slots[r_wr_ptr] <= i_din;
            r_wr_ptr          <= r_wr_ptr + LOG2_N'(1'b1);
        end
    end

endmodule

// File: rtl/moving_avg.sv
// Windowed running mean over the last N = 2**LOG2_N samples.
//   clock, reset_n : clock and async active-low reset
//   enable         : 1 = advance, 0 = hold all state (ovalid forced low)
//   sign           : 1 = two's-complement samples, 0 = unsigned
//   flush          : synchronous clear of window, sum, count, primed, in-flight
//   bus (slave)    : DIN/ivalid in, DOUT/ovalid/primed out
// Stage 1 updates the running sum on the accepting edge; stage 2 shifts it
// into DOUT one edge later.
module moving_avg
    import moving_avg_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int LOG2_N = 3
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          enable,
    input  logic          sign,
    input  logic          flush,
    moving_avg_if.slave   bus
);
    localparam int SUM_W = sum_width(WIDTH, LOG2_N);
    localparam int N     = 1 << LOG2_N;
    localparam logic [LOG2_N:0] COUNT_FULL = (LOG2_N + 1)'(N);
    localparam logic [LOG2_N:0] COUNT_ONE  = (LOG2_N + 1)'(1);

    logic             w_accept;
    logic [WIDTH-1:0] w_old;
    logic [SUM_W-1:0] w_new_ext;
    logic [SUM_W-1:0] w_old_ext;
    logic [SUM_W-1:0] w_sum_next;
    logic [WIDTH-1:0] w_mean;

    logic [SUM_W-1:0] r_sum;
    logic [LOG2_N:0]  r_count;
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_dout;
    logic             r_ovalid;
    logic             r_primed;

    // flush wins over a coincident sample, which is dropped.
    assign w_accept = enable & bus.ivalid & ~flush;

    moving_avg_ring #(
        .WIDTH  (WIDTH),
        .LOG2_N (LOG2_N)
    ) u_ring (
        .clock   (clock),
        .reset_n (reset_n),
        .i_clear (flush),
        .i_wr_en (w_accept),
        .i_din   (bus.DIN),
        .o_old   (w_old)
    );

    // Extend incoming and departing samples to the accumulator width.
    always_comb begin
        w_new_ext = '0;
        w_old_ext = '0;
        if (sign == SIGN_SIGNED) begin
            w_new_ext = {{LOG2_N{bus.DIN[WIDTH-1]}}, bus.DIN};
            w_old_ext = {{LOG2_N{w_old[WIDTH-1]}}, w_old};
        end else begin
            w_new_ext = {{LOG2_N{1'b0}}, bus.DIN};
            w_old_ext = {{LOG2_N{1'b0}}, w_old};
        end
    end

    // Modular add/subtract is exact because the true sum always fits SUM_W.
    assign w_sum_next = r_sum + w_new_ext - w_old_ext;

    // Divide by N with floor semantics matching the sample signedness.
    always_comb begin
        w_mean = '0;
        if (sign == SIGN_SIGNED) begin
            w_mean = WIDTH'($signed(r_sum) >>> LOG2_N);
        end else begin
            w_mean = WIDTH'(r_sum >> LOG2_N);
        end
    end

    // Stage 1: running sum, saturating fill count and in-flight flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sum      <= '0;
            r_count    <= '0;
            r_s1_valid <= 1'b0;
        end else if (flush) begin
            r_sum      <= '0;
            r_count    <= '0;
            r_s1_valid <= 1'b0;
        end else if (enable) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_sum <= w_sum_next;
                if (r_count != COUNT_FULL) begin
                    r_count <= r_count + COUNT_ONE;
                end
            end
        end
    end

    // Stage 2: registered mean, valid pulse and primed flag. A stage-1 result
    // held across enable=0 is emitted on the first enabled edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_dout   <= '0;
            r_ovalid <= 1'b0;
            r_primed <= 1'b0;
        end else if (flush) begin
            r_ovalid <= 1'b0;
            r_primed <= 1'b0;
        end else if (enable) begin
            r_ovalid <= r_s1_valid;
            if (r_s1_valid) begin
                r_dout <= w_mean;
                // count already includes the sample carried by stage 1
                if (r_count == COUNT_FULL) begin
                    r_primed <= 1'b1;
                end
            end
        end else begin
            r_ovalid <= 1'b0;
        end
    end

    assign bus.DOUT   = r_dout;
    assign bus.ovalid = r_ovalid;
    assign bus.primed = r_primed;

endmodule

// File: tb/tb_moving_avg.sv
module tb_moving_avg;

    typedef logic [15:0] vec_t [16];

    logic clock;
    logic reset_n;
    logic enable;
    logic sign;
    logic flush;

    int checks;
    int errors;

    moving_avg_if #(.WIDTH(16)) bus ();

    moving_avg #(
        .WIDTH  (16),
        .LOG2_N (3)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (enable),
        .sign    (sign),
        .flush   (flush),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Drive n samples back-to-back from a negedge, collect every ovalid result.
    task automatic send_capture(input int n, input vec_t vals,
                                output vec_t outs, output vec_t prim, output int got);
        got = 0;
        for (int i = 0; i < 16; i++) begin
            outs[i] = 16'h0000;
            prim[i] = 16'h0000;
        end
        for (int c = 0; c < n + 4; c++) begin
            if (c < n) begin
                bus.DIN    = vals[c];
                bus.ivalid = 1'b1;
            end else begin
                bus.ivalid = 1'b0;
            end
            @(negedge clock);
            if (bus.ovalid === 1'b1 && got < 16) begin
                outs[got] = bus.DOUT;
                prim[got] = {15'd0, bus.primed};
                got++;
            end
        end
    endtask

    task automatic do_flush();
        @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checks++;
            if (bus.DOUT !== 16'h0000 || bus.ovalid !== 1'b0 || bus.primed !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: DOUT=%h ovalid=%b primed=%b required 0000/0/0",
                         bus.DOUT, bus.ovalid, bus.primed);
            end
            bus.DIN    = 16'(i * 1234 + 7);
            bus.ivalid = ~bus.ivalid;
        end
        @(negedge clock);
        bus.ivalid = 1'b0;
        reset_n    = 1'b1;
        @(negedge clock);
        bus.DIN    = 16'd40;
        bus.ivalid = 1'b1;
        @(negedge clock);
        bus.ivalid = 1'b0;
        checks++;
        if (bus.ovalid !== 1'b0) begin
            errors++;
            $display("FAIL latency_1clk: ovalid=%b required 0", bus.ovalid);
        end
        @(negedge clock);
        checks++;
        if (bus.ovalid !== 1'b1 || bus.DOUT !== 16'd5 || bus.primed !== 1'b0) begin
            errors++;
            $display("FAIL latency_2clk: ovalid=%b DOUT=%0d primed=%b required 1/5/0",
                     bus.ovalid, bus.DOUT, bus.primed);
        end
        @(negedge clock);
        checks++;
        if (bus.ovalid !== 1'b0) begin
            errors++;
            $display("FAIL latency_pulse: ovalid=%b required 0", bus.ovalid);
        end
    endtask

    task automatic test_unsigned_fill();
        vec_t vals, outs, prim;
        int   got;
        // mid-stream reset: the earlier sample of 40 must be forgotten
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        sign    = 1'b0;
        for (int i = 0; i < 16; i++) vals[i] = 16'd16;
        send_capture(8, vals, outs, prim, got);
        checks++;
        if (got !== 8) begin
            errors++;
            $display("FAIL fill_count: got %0d results required 8", got);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (outs[k] !== 16'(2 * (k + 1))) begin
                errors++;
                $display("FAIL fill_dout[%0d]: got %0d required %0d", k, outs[k], 2 * (k + 1));
            end
        end
        checks++;
        if (prim[6] !== 16'd0 || prim[7] !== 16'd1) begin
            errors++;
            $display("FAIL fill_primed: 7th=%0d 8th=%0d required 0/1", prim[6], prim[7]);
        end
    endtask

    task automatic test_signed();
        vec_t vals, outs, prim;
        int   got;
        do_flush();
        sign = 1'b1;
        for (int i = 0; i < 16; i++) vals[i] = 16'hFFE1;
        send_capture(8, vals, outs, prim, got);
        checks++;
        if (got !== 8 || outs[0] !== 16'hFFFC || outs[7] !== 16'hFFE1) begin
            errors++;
            $display("FAIL signed_neg31: got=%0d first=%h last=%h required 8/fffc/ffe1",
                     got, outs[0], outs[7]);
        end
    endtask

    task automatic test_wrap();
        vec_t vals, outs, prim;
        int   got;
        int   exp_tail [8];
        exp_tail = '{87, 75, 62, 50, 37, 25, 12, 0};
        do_flush();
        sign = 1'b0;
        for (int i = 0; i < 16; i++) vals[i] = (i < 8) ? 16'd100 : 16'd0;
        send_capture(16, vals, outs, prim, got);
        checks++;
        if (got !== 16) begin
            errors++;
            $display("FAIL wrap_count: got %0d results required 16", got);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (outs[8 + k] !== 16'(exp_tail[k])) begin
                errors++;
                $display("FAIL wrap_dout[%0d]: got %0d required %0d", k, outs[8 + k], exp_tail[k]);
            end
        end
    endtask

    task automatic test_extremes();
        vec_t vals, outs, prim;
        int   got;
        do_flush();
        sign = 1'b1;
        for (int i = 0; i < 16; i++) vals[i] = 16'h8000;
        send_capture(8, vals, outs, prim, got);
        checks++;
        if (got !== 8 || outs[7] !== 16'h8000) begin
            errors++;
            $display("FAIL ext_min: got=%0d last=%h required 8/8000", got, outs[7]);
        end
        for (int i = 0; i < 16; i++) vals[i] = 16'h7FFF;
        send_capture(8, vals, outs, prim, got);
        checks++;
        if (got !== 8 || outs[7] !== 16'h7FFF) begin
            errors++;
            $display("FAIL ext_max: got=%0d last=%h required 8/7fff", got, outs[7]);
        end
        do_flush();
        sign = 1'b0;
        for (int i = 0; i < 16; i++) vals[i] = 16'hFFFF;
        send_capture(8, vals, outs, prim, got);
        checks++;
        if (got !== 8 || outs[7] !== 16'hFFFF || prim[7] !== 16'd1) begin
            errors++;
            $display("FAIL ext_umax: got=%0d last=%h primed=%0d required 8/ffff/1",
                     got, outs[7], prim[7]);
        end
    endtask

    task automatic test_flush_enable();
        // window currently full of 0xFFFF, primed high
        @(negedge clock);
        flush      = 1'b1;
        bus.DIN    = 16'd80;
        bus.ivalid = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        checks++;
        if (bus.primed !== 1'b0 || bus.ovalid !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear: primed=%b ovalid=%b required 0/0", bus.primed, bus.ovalid);
        end
        @(negedge clock);
        bus.ivalid = 1'b0;
        checks++;
        if (bus.ovalid !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop: ovalid=%b required 0", bus.ovalid);
        end
        @(negedge clock);
        checks++;
        if (bus.ovalid !== 1'b1 || bus.DOUT !== 16'd10 || bus.primed !== 1'b0) begin
            errors++;
            $display("FAIL flush_next: ovalid=%b DOUT=%0d primed=%b required 1/10/0",
                     bus.ovalid, bus.DOUT, bus.primed);
        end
        @(negedge clock);
        checks++;
        if (bus.ovalid !== 1'b0) begin
            errors++;
            $display("FAIL flush_single: ovalid=%b required 0", bus.ovalid);
        end
        // ivalid while disabled must not touch the window or sum
        enable     = 1'b0;
        bus.DIN    = 16'd800;
        bus.ivalid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            checks++;
            if (bus.ovalid !== 1'b0) begin
                errors++;
                $display("FAIL disabled_idle[%0d]: ovalid=%b required 0", c, bus.ovalid);
            end
        end
        // accept 8, then stall with the result in flight
        enable  = 1'b1;
        bus.DIN = 16'd8;
        @(negedge clock);
        enable  = 1'b0;
        bus.DIN = 16'd800;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            checks++;
            if (bus.ovalid !== 1'b0) begin
                errors++;
                $display("FAIL disabled_hold[%0d]: ovalid=%b required 0", c, bus.ovalid);
            end
        end
        enable     = 1'b1;
        bus.ivalid = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.ovalid !== 1'b1 || bus.DOUT !== 16'd11) begin
            errors++;
            $display("FAIL enable_resume: ovalid=%b DOUT=%0d required 1/11", bus.ovalid, bus.DOUT);
        end
        @(negedge clock);
        checks++;
        if (bus.ovalid !== 1'b0) begin
            errors++;
            $display("FAIL enable_pulse: ovalid=%b required 0", bus.ovalid);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset_n    = 1'b0;
        enable     = 1'b1;
        sign       = 1'b0;
        flush      = 1'b0;
        bus.DIN    = 16'h0000;
        bus.ivalid = 1'b0;
        test_reset();
        test_unsigned_fill();
        test_signed();
        test_wrap();
        test_extremes();
        test_flush_enable();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
